duty_ramp: RTL and testbench
============================

// Module: duty_ramp
//
// PURPOSE
// - Upstream sequencer for the DDR PWM stage: drives its 10-bit duty_cycle input.
// - Accepts a ramp command (target, step, hold) over valid/ready.
// - Slews duty_cycle toward the target one step per (hold+1) PWM periods.
// - Updates only on PWM period boundaries, so the PWM stage never sees a mid-period change.
//
// PARAMETERS
// - PERIOD_BITS  8        width of the internal period counter; period = 2**PERIOD_BITS clk; matches the PWM stage
// - MAX_DUTY     10'd1000 ceiling for duty_cycle; used only when DUTY_LIMIT_EN is defined
//
// PORTS
// - clk         in   1   system clock; same clock as the PWM stage
// - rst         in   1   asynchronous, active-high reset
// - cmd_valid   in   1   command present
// - cmd_ready   out  1   high only in IDLE; a command is accepted on a clk edge with valid&&ready
// - cmd_target  in  10   final duty value
// - cmd_step    in  10   magnitude of each duty change; 0 is treated as 1
// - cmd_hold    in   8   extra periods between steps; 0 = step every period
// - abort       in   1   stop the ramp, freeze duty_cycle, return to IDLE
// - duty_cycle  out 10   registered; feeds the PWM stage's duty_cycle
// - busy        out  1   high in RAMP
// - done        out  1   one-cycle pulse when duty_cycle reaches the target
//
// BEHAVIOUR
// - Reset values: duty_cycle=0, busy=0, done=0, cmd_ready=1.
// - Reset also sets state=IDLE, period counter pcnt=0, hold_cnt=0.
// - Reset mid-ramp takes effect immediately (asynchronous).
// - pcnt: free-running PERIOD_BITS-bit up-counter; wraps all-ones -> 0.
// - Boundary: the cycle in which pcnt == all-ones.
//   - Any duty update made at a boundary becomes visible in the same edge that sets pcnt to 0.
// - States:
//   - IDLE: cmd_ready=1.
//     - On accept: latch target, step (0 -> 1) and hold; set hold_cnt=cmd_hold.
//     - If cmd_target == duty_cycle: done=1 on the next cycle and stay in IDLE.
//     - Otherwise go to RAMP.
//   - RAMP: busy=1, cmd_ready=0. Action at each boundary:
//     - If hold_cnt != 0: hold_cnt decrements.
//     - Else: hold_cnt reloads from hold; duty moves one step toward target.
//   - Step arithmetic: computed in 11 bits, no wrap.
//     - Up: duty = min(duty+step, target).
//     - Down: duty = (duty < step) ? target : max(duty-step, target).
//   - Completion: when the new duty equals target, done pulses for 1 cycle in the same edge.
//     - The state returns to IDLE in that same edge; cmd_ready is high on the following cycle.
// - abort in RAMP: next edge goes to IDLE; duty_cycle holds its value; done stays 0.
//   - abort in IDLE is ignored and does not block accept.
// - abort coinciding with a step boundary: abort wins; no duty update.
// - Command acceptance does not depend on pcnt.
//   - The first step lands at the first boundary after (hold) skipped boundaries.
// - Latency from accept to first duty change: 1..2**PERIOD_BITS + hold*2**PERIOD_BITS clk.
// - duty_cycle bit 0 passes through unchanged; the PWM stage ignores it.
//
// CONFIGURATION
// - DUTY_LIMIT_EN defined:
//   - A latched target above MAX_DUTY is replaced by MAX_DUTY.
//   - duty_cycle never exceeds MAX_DUTY.
// - DUTY_LIMIT_EN undefined: targets pass unmodified; full 0..1023 range.
//
// TESTING
// - Reset: rst pulse -> duty_cycle=0, busy=0, done=0, cmd_ready=1.
// - Up ramp: from 0, target=100, step=30, hold=0.
//   - duty_cycle 30,60,90,100 on four consecutive pcnt wraps.
//   - done pulses once with 100; busy drops.
// - Down ramp with clamp: from 100, target=10, step=40, hold=1.
//   - duty_cycle 60 then 20 then 10, each change 512 clk apart.
// - No-op and step=0: target == current -> done the next cycle, no RAMP.
//   - step=0, target=current+2 -> two unit steps.
// - Abort: abort asserted in the same cycle as a boundary mid-ramp.
//   - No update at that boundary, IDLE next cycle, duty frozen.
//   - cmd_valid held high during RAMP is not accepted until IDLE.
// - DUTY_LIMIT_EN: target=1023 with MAX_DUTY=1000 -> ramp ends at 1000 with done.
//   - Without the macro, the same command ends at 1023.

Source files
------------

// File: rtl/duty_ramp.sv
// Duty-cycle ramp sequencer for the PWM stage: slews duty_cycle toward a commanded
// target only at PWM period boundaries. Optional ceiling enabled by `define DUTY_LIMIT_EN.
module duty_ramp #(
    parameter int PERIOD_BITS = 8
`ifdef DUTY_LIMIT_EN
    ,
    parameter logic [9:0] MAX_DUTY = 10'd1000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_target,
    input  logic [9:0] cmd_step,
    input  logic [7:0] cmd_hold,
    input  logic       abort,
    output logic [9:0] duty_cycle,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t                 state, state_next;
    logic [PERIOD_BITS-1:0] pcnt;
    logic [9:0]             target, target_next, step, step_next, duty_next;
    logic [7:0]             hold, hold_next, hold_cnt, hold_cnt_next;
    logic                   done_next;
    logic                   boundary;
    logic [9:0]             target_in, step_in, stepped;
    logic [10:0]            up_sum, down_diff;

    assign boundary  = &pcnt;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RAMP);
    assign step_in   = (cmd_step == 10'd0) ? 10'd1 : cmd_step;

`ifdef DUTY_LIMIT_EN
    assign target_in = (cmd_target > MAX_DUTY) ? MAX_DUTY : cmd_target;
`else
    assign target_in = cmd_target;
`endif

    // 11-bit arithmetic so neither direction can wrap past the target.
    assign up_sum    = {1'b0, duty_cycle} + {1'b0, step};
    assign down_diff = {1'b0, duty_cycle} - {1'b0, step};

    always_comb begin
        stepped = target;
        if (target > duty_cycle) begin
            stepped = (up_sum > {1'b0, target}) ? target : up_sum[9:0];
        end else if (duty_cycle >= step && down_diff[9:0] > target) begin
            stepped = down_diff[9:0];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next    = state;
        target_next   = target;
        step_next     = step;
        hold_next     = hold;
        hold_cnt_next = hold_cnt;
        duty_next     = duty_cycle;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    target_next   = target_in;
                    step_next     = step_in;
                    hold_next     = cmd_hold;
                    hold_cnt_next = cmd_hold;
                    if (target_in == duty_cycle) done_next  = 1'b1;
                    else                         state_next = RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (boundary) begin
                    if (hold_cnt != 8'd0) begin
                        hold_cnt_next = hold_cnt - 8'd1;
                    end else begin
                        hold_cnt_next = hold;
                        duty_next     = stepped;
                        if (stepped == target) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pcnt       <= '0;
            target     <= '0;
            step       <= 10'd1;
            hold       <= '0;
            hold_cnt   <= '0;
            duty_cycle <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            pcnt       <= pcnt + 1'b1;
            target     <= target_next;
            step       <= step_next;
            hold       <= hold_next;
            hold_cnt   <= hold_cnt_next;
            duty_cycle <= duty_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: a model pushes expected duty/done events to a
// scoreboard when a command is driven; a negedge monitor pops and compares them.
module tb_duty_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] cmd_target = '0;
    logic [9:0] cmd_step = '0;
    logic [7:0] cmd_hold = '0;
    logic       cmd_ready, busy, done;
    logic [9:0] duty_cycle;

    duty_ramp dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_hold   (cmd_hold),
        .abort      (abort),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int done;
        int gap;   // expected clk since previous duty change; 0 = unchecked
    } evt_t;

    evt_t       sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc;
    int         last_cyc = 0;
    int         m_duty = 0;
    logic [9:0] prev_duty = '0;
    evt_t       e;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    endtask

    // Edges since reset release; equals the DUT period counter modulo 256.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && (duty_cycle != prev_duty || done)) begin
            if (sb.size() == 0) begin
                check("sb_has_event", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("duty", int'(duty_cycle), e.duty);
                check("done", int'(done), e.done);
                if (duty_cycle != prev_duty) begin
                    check("wrap_align", cyc % 256, 0);
                    if (e.gap != 0) check("step_gap", cyc - last_cyc, e.gap);
                    last_cyc = cyc;
                end
            end
        end
        prev_duty = duty_cycle;
    end

    task automatic push_ramp(input int t, input int s, input int h);
        int d;
        int first;
        d = m_duty;
        first = 1;
`ifdef DUTY_LIMIT_EN
        if (t > 1000) t = 1000;
`endif
        if (s == 0) s = 1;
        if (t == d) sb.push_back('{d, 1, 0});
        while (d != t) begin
            if (t > d) d = (d + s > t) ? t : d + s;
            else       d = (d < s) ? t : ((d - s < t) ? t : d - s);
            sb.push_back('{d, (d == t) ? 1 : 0, first ? 0 : 256 * (h + 1)});
            first = 0;
        end
        m_duty = d;
    endtask

    task automatic send_cmd(input int t, input int s, input int h);
        push_ramp(t, s, h);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = 10'(t);
        cmd_step   = 10'(s);
        cmd_hold   = 8'(h);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_duty", int'(duty_cycle), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);
        rst = 1'b0;

        // Up ramp: 30, 60, 90, 100 on consecutive wraps.
        repeat (5) @(negedge clk);
        send_cmd(100, 30, 0);
        check("up_busy", int'(busy), 1);
        check("up_ready_low", int'(cmd_ready), 0);
        wait_drain("up");
        check("up_end_busy", int'(busy), 0);
        check("up_end_ready", int'(cmd_ready), 1);

        // Down ramp with clamp, hold=1: 60, 20, 10 every 512 clk.
        send_cmd(10, 40, 1);
        wait_drain("down");

        // No-op command: done next cycle, never enters RAMP.
        send_cmd(10, 5, 0);
        check("noop_busy", int'(busy), 0);
        wait_drain("noop");

        // step=0 acts as 1.
        send_cmd(12, 0, 0);
        wait_drain("step0");

        // Abort at a boundary while another command waits on cmd_valid.
        sb.push_back('{112, 0, 0});
        sb.push_back('{212, 0, 256});
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = 10'd500;
        cmd_step   = 10'd100;
        cmd_hold   = 8'd0;
        @(negedge clk);
        cmd_target = 10'd7;
        cmd_step   = 10'd1000;
        check("held_ready_low", int'(cmd_ready), 0);
        check("held_busy", int'(busy), 1);
        wait_drain("abort_pre");
        while (cyc % 256 != 255) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_freeze", int'(duty_cycle), 212);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_done", int'(done), 0);
        m_duty = 212;
        push_ramp(7, 1000, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_accepted", int'(busy), 1);
        wait_drain("held");

        // Full-scale target; ends at 1000 only when the ceiling is compiled in.
        send_cmd(1023, 300, 0);
        wait_drain("limit");
        check("final_duty", int'(duty_cycle), m_duty);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
